div_sched: RTL

- Sequential divide unit shared by two requesters, e.g. the execute stage and a second issue port.
- Round-robin arbitration picks one request at a time.
- A radix-2 restoring divider computes one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag to the granted requester over a valid/ready response channel.
- Replaces the combinational divider in the CPU datapath to cut the critical path.

---
 rtl/div_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/div_sched.sv
// div_sched: sequential unsigned divider shared by two requesters.
//
// Round-robin arbitration selects one request at a time in IDLE. A radix-2
// restoring divider then produces one quotient bit per clock, and the result
// goes back over a valid/ready response channel tagged with the requester id.
// A zero divisor skips the iterations and returns quotient = all ones,
// remainder = dividend, div_by_zero = 1.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   reqX_valid / reqX_ready      request handshake for requester X (0/1);
//                                ready is combinational and high only in IDLE
//   reqX_dividend / reqX_divisor operands for requester X, sampled on accept
//   resp_valid / resp_ready      response handshake
//   resp_id                      requester that the result belongs to
//   quotient, remainder          result, stable while resp_valid is high
//   div_by_zero                  divisor was zero
//   busy                         unit is not idle
module div_sched #(
  parameter int N  = 16,
  parameter int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_dividend,
  input  logic [N-1:0] req0_divisor,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_dividend,
  input  logic [N-1:0] req1_divisor,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic          last_grant_q;
  logic          id_q;
  logic [N-1:0]  rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic          resp_valid_q;
  logic          resp_id_q;
  logic [N-1:0]  quot_q;
  logic [N-1:0]  remd_q;
  logic          dbz_q;

  logic          grant;
  logic          accept;
  logic [N-1:0]  sel_dividend;
  logic [N-1:0]  sel_divisor;
  logic [N:0]    trial;
  logic          fits;
  logic [N-1:0]  rem_d;
  logic [N-1:0]  quo_d;

  // With both requesters valid the one not granted last time wins; a lone
  // requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  assign req0_ready   = (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready   = (state_q == IDLE) && req1_valid &&  grant;
  assign accept       = req0_ready || req1_ready;
  assign sel_dividend = grant ? req1_dividend : req0_dividend;
  assign sel_divisor  = grant ? req1_divisor  : req0_divisor;

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract when it fits. The difference is always below the divisor,
  // so N-bit arithmetic on the low bits gives the exact result.
  assign trial = {rem_q, quo_q[N-1]};
  assign fits  = (trial >= {1'b0, dvs_q});
  assign rem_d = fits ? (trial[N-1:0] - dvs_q) : trial[N-1:0];
  assign quo_d = {quo_q[N-2:0], fits};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvs_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      quot_q       <= '0;
      remd_q       <= '0;
      dbz_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            last_grant_q <= grant;
            id_q         <= grant;
            dvs_q        <= sel_divisor;
            if (sel_divisor == '0) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_id_q    <= grant;
              quot_q       <= '1;
              remd_q       <= sel_dividend;
              dbz_q        <= 1'b1;
            end else begin
              state_q <= RUN;
              rem_q   <= '0;
              quo_q   <= sel_dividend;
              cnt_q   <= CW'(N);
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          // The iteration that sees count == 1 produces the last quotient bit.
          if (cnt_q == CW'(1)) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
            resp_id_q    <= id_q;
            quot_q       <= quo_d;
            remd_q       <= rem_d;
            dbz_q        <= 1'b0;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != IDLE);

endmodule
